dino_jump_engine: RTL and testbench

Parametrised successor to the dinosaur jump/sprite block. It runs a frame-stepped jump trajectory under an explicit game FSM (idle / ground / air / over), with press-edge detection, jump buffering near landing, and a collision stop. It renders the sprite through a pipelined fetch from an external synchronous sprite ROM. It sits between the VGA scan counters and the pixel mixer, in the single CLK domain.

---
 rtl/dino_jump_engine_pkg.sv | 21 ++
 rtl/dino_jump_engine_if.sv | 17 +
 rtl/dino_jump_engine_trajectory.sv | 83 ++++++++
 rtl/dino_jump_engine.sv | 168 ++++++++++++++++
 tb/tb_dino_jump_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_jump_engine_pkg.sv
// Shared game-state encoding and trajectory helpers for the dino jump engine.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GROUND = 2'd1,
    ST_AIR    = 2'd2,
    ST_OVER   = 2'd3
  } game_state_e;

  // Frame counter width; JUMP_FRAMES is limited to 254.
  localparam int T_CNT_W = 8;

  // Apex of t*(T-t)/2, reached at t = T/2 for even T.
  function automatic int unsigned max_height(input int unsigned frames);
    int unsigned half;
    half = frames / 32'd2;
    return (half * (frames - half)) / 32'd2;
  endfunction

endpackage

// File: rtl/dino_jump_engine_if.sv
// Scan-position / sprite-ROM / pixel bundle between the VGA counters, ROM and mixer.
interface dino_jump_engine_if #(
  parameter int ROW_W  = 9,
  parameter int COL_W  = 10,
  parameter int ADDR_W = 13
);
  logic [ROW_W-1:0]  row_addr;
  logic [COL_W-1:0]  col_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_data;
  logic              px;

  modport master (output row_addr, output col_addr, output rom_data,
                  input  rom_addr, input  px);
  modport slave  (input  row_addr, input  col_addr, input  rom_data,
                  output rom_addr, output px);
endinterface

// File: rtl/dino_jump_engine_trajectory.sv
// Frame counter t, landing buffer and registered height t*(T-t)/2 for one jump.
module jump_trajectory
  import dino_pkg::*;
#(
  parameter int JUMP_FRAMES   = 30,
  parameter int BUFFER_FRAMES = 4,
  parameter int HEIGHT_W      = 12
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                restart,
  input  logic                takeoff,
  input  logic                air_tick,
  input  logic                air_press,
  output logic                land,
  output logic [HEIGHT_W-1:0] height
);

  localparam logic [T_CNT_W-1:0] T_LAST = T_CNT_W'(JUMP_FRAMES - 1);
  localparam logic [T_CNT_W-1:0] BUF_LO = T_CNT_W'(JUMP_FRAMES - BUFFER_FRAMES);
  localparam logic               BUF_EN = (BUFFER_FRAMES > 0);

  logic [T_CNT_W-1:0]  t_r, t_next_s;
  logic                buf_r, buf_next_s;
  logic                press_ok_s;
  logic [HEIGHT_W-1:0] height_r, height_next_s;
  logic [HEIGHT_W-1:0] t_ext_s, rem_s, prod_s;

  assign press_ok_s = air_press & BUF_EN & (t_r >= BUF_LO);
  // A press arriving on the landing tick itself still counts as buffered.
  assign land       = (t_r == T_LAST) & ~(buf_r | press_ok_s);
  assign height     = height_r;

  // Next t / buffer from the qualified enables, and the matching height.
  always_comb begin
    t_next_s      = t_r;
    buf_next_s    = buf_r;
    t_ext_s       = '0;
    rem_s         = '0;
    prod_s        = '0;
    height_next_s = '0;
    if (restart) begin
      t_next_s   = '0;
      buf_next_s = 1'b0;
    end else if (takeoff) begin
      t_next_s   = T_CNT_W'(1);
      buf_next_s = 1'b0;
    end else if (air_tick) begin
      if (t_r < T_LAST) begin
        t_next_s   = t_r + T_CNT_W'(1);
        buf_next_s = buf_r | press_ok_s;
      end else if (buf_r | press_ok_s) begin
        t_next_s   = T_CNT_W'(1);
        buf_next_s = 1'b0;
      end else begin
        t_next_s   = '0;
        buf_next_s = 1'b0;
      end
    end else if (press_ok_s) begin
      buf_next_s = 1'b1;
    end else begin
      buf_next_s = buf_r;
    end
    t_ext_s       = HEIGHT_W'(t_next_s);
    rem_s         = HEIGHT_W'(JUMP_FRAMES) - t_ext_s;
    prod_s        = t_ext_s * rem_s;
    height_next_s = {1'b0, prod_s[HEIGHT_W-1:1]};
  end

  // Trajectory registers; height updates on the same edge as t.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      t_r      <= '0;
      buf_r    <= 1'b0;
      height_r <= '0;
    end else begin
      t_r      <= t_next_s;
      buf_r    <= buf_next_s;
      height_r <= height_next_s;
    end
  end

endmodule

// File: rtl/dino_jump_engine.sv
// Dino game FSM (idle/ground/air/over) plus 2-cycle sprite render pipeline
// fetching from an external synchronous sprite ROM.
module dino_jump_engine
  import dino_pkg::*;
#(
  parameter int SPRITE_W      = 82,
  parameter int SPRITE_H      = 88,
  parameter int X_POS         = 80,
  parameter int GROUND_Y      = 402,
  parameter int JUMP_FRAMES   = 30,
  parameter int BUFFER_FRAMES = 4,
  parameter int ROW_W         = 9,
  parameter int COL_W         = 10,
  parameter int HEIGHT_W      = 12,
  parameter int ADDR_W        = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                fresh,
  input  logic                button_jump,
  input  logic                collision,
  dino_jump_engine_if.slave   vid,
  output logic                game_status,
  output logic                airborne,
  output logic [HEIGHT_W-1:0] height
);

  localparam int                 BOX_W  = ROW_W + 2;
  localparam logic [COL_W:0]     X_LO   = (COL_W + 1)'(X_POS);
  localparam logic [COL_W:0]     X_HI   = (COL_W + 1)'(X_POS + SPRITE_W);
  localparam logic [ADDR_W-1:0]  SW_A   = ADDR_W'(SPRITE_W);

  game_state_e         state_r, state_next_s;
  logic                fresh_d_r, btn_d_r;
  logic                jump_req_r, jump_req_next_s;
  logic                tick_s, press_s;
  logic                restart_s, takeoff_s, air_tick_s, air_press_s, land_s;
  logic [HEIGHT_W-1:0] height_s;

  logic signed [BOX_W-1:0] row_s, bottom_s, top_s, row_off_s;
  logic [COL_W:0]          col_s;
  logic                    hit_s;
  logic [ADDR_W-1:0]       addr_s;
  logic                    hit_r, hit_d_r, px_r;
  logic [ADDR_W-1:0]       rom_addr_r;

  assign tick_s  = fresh_d_r & ~fresh;
  assign press_s = button_jump & ~btn_d_r;

  jump_trajectory #(
    .JUMP_FRAMES   (JUMP_FRAMES),
    .BUFFER_FRAMES (BUFFER_FRAMES),
    .HEIGHT_W      (HEIGHT_W)
  ) u_traj (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .restart   (restart_s),
    .takeoff   (takeoff_s),
    .air_tick  (air_tick_s),
    .air_press (air_press_s),
    .land      (land_s),
    .height    (height_s)
  );

  // Next state and trajectory enables; collision freezes everything in play.
  always_comb begin
    state_next_s    = state_r;
    jump_req_next_s = jump_req_r;
    restart_s       = 1'b0;
    takeoff_s       = 1'b0;
    air_tick_s      = 1'b0;
    air_press_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (press_s) begin
          state_next_s    = ST_GROUND;
          restart_s       = 1'b1;
          jump_req_next_s = 1'b0;
        end else begin
          state_next_s    = state_r;
        end
      end
      ST_GROUND: begin
        if (collision) begin
          state_next_s    = ST_OVER;
        end else if (tick_s && (jump_req_r || press_s)) begin
          state_next_s    = ST_AIR;
          takeoff_s       = 1'b1;
          jump_req_next_s = 1'b0;
        end else if (press_s) begin
          jump_req_next_s = 1'b1;
        end else begin
          jump_req_next_s = jump_req_r;
        end
      end
      ST_AIR: begin
        if (collision) begin
          state_next_s = ST_OVER;
        end else begin
          air_tick_s   = tick_s;
          air_press_s  = press_s;
          if (tick_s && land_s) begin
            state_next_s = ST_GROUND;
          end else begin
            state_next_s = ST_AIR;
          end
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        jump_req_next_s = 1'b0;
      end
    endcase
  end

  // Game state, pending jump request and edge-detect flops.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      jump_req_r <= 1'b0;
      fresh_d_r  <= 1'b0;
      btn_d_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      jump_req_r <= jump_req_next_s;
      fresh_d_r  <= fresh;
      btn_d_r    <= button_jump;
    end
  end

  // Sprite bounding box in signed row space and ROM address of the scan point.
  always_comb begin
    row_s     = $signed({2'b00, vid.row_addr});
    col_s     = {1'b0, vid.col_addr};
    bottom_s  = $signed(BOX_W'(GROUND_Y)) - $signed(BOX_W'(height_s));
    top_s     = bottom_s - $signed(BOX_W'(SPRITE_H));
    row_off_s = row_s - top_s;
    hit_s     = (state_r != ST_IDLE) && (row_s >= top_s) && (row_s < bottom_s)
                && (col_s >= X_LO) && (col_s < X_HI);
    addr_s    = ADDR_W'($unsigned(row_off_s)) * SW_A + ADDR_W'(col_s - X_LO);
  end

  // Render pipeline: address/hit at edge k, ROM read at k+1, pixel at k+2.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hit_r      <= 1'b0;
      hit_d_r    <= 1'b0;
      px_r       <= 1'b0;
      rom_addr_r <= '0;
    end else begin
      hit_r   <= hit_s;
      hit_d_r <= hit_r;
      px_r    <= hit_d_r & vid.rom_data;
      if (hit_s) begin
        rom_addr_r <= addr_s;
      end else begin
        rom_addr_r <= rom_addr_r;
      end
    end
  end

  assign vid.rom_addr = rom_addr_r;
  assign vid.px       = px_r;
  assign game_status  = (state_r == ST_GROUND) || (state_r == ST_AIR);
  assign airborne     = (state_r == ST_AIR);
  assign height       = height_s;

endmodule

// File: tb/tb_dino_jump_engine.sv
// Self-checking bench: vector table, hand-written jump sequences and random play
// against a rule-level reference model of the game and sprite renderer.
module tb_dino_jump_engine;

  localparam int T  = 30;
  localparam int BF = 4;
  localparam int SW = 82;
  localparam int SH = 88;
  localparam int XP = 80;
  localparam int GY = 402;

  localparam int M_IDLE = 0, M_GROUND = 1, M_AIR = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        rst_n, fresh, button_jump, collision;
  logic        game_status, airborne;
  logic [11:0] height;

  dino_jump_engine_if #(.ROW_W(9), .COL_W(10), .ADDR_W(13)) vif ();

  dino_jump_engine dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .fresh       (fresh),
    .button_jump (button_jump),
    .collision   (collision),
    .vid         (vif),
    .game_status (game_status),
    .airborne    (airborne),
    .height      (height)
  );

  always #5 clk = ~clk;

  // Synchronous ROM whose content is the low address bit.
  always @(posedge clk) vif.rom_data <= vif.rom_addr[0];

  int total = 0;
  int bad   = 0;

  int m_st, m_t, m_buf, m_req, m_fd, m_bd, m_addr, m_px;
  int m_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int m_height(input int t);
    return t * (T - t) / 2;
  endfunction

  task automatic model_step();
    int tick, press, press_ok, row, col, top, bot, hit;
    if (!rst_n) begin
      m_st = M_IDLE; m_t = 0; m_buf = 0; m_req = 0; m_fd = 0; m_bd = 0;
      m_addr = 0; m_q = '{0, 0}; m_px = 0;
      return;
    end
    tick  = (m_fd == 1 && fresh == 1'b0) ? 1 : 0;
    press = (button_jump == 1'b1 && m_bd == 0) ? 1 : 0;
    row = int'(vif.row_addr);
    col = int'(vif.col_addr);
    bot = GY - m_height(m_t);
    top = bot - SH;
    hit = (m_st != M_IDLE && row >= top && row < bot && col >= XP && col < XP + SW) ? 1 : 0;
    if (hit == 1) m_addr = (row - top) * SW + (col - XP);
    m_q.push_back((hit == 1) ? (m_addr % 2) : 0);
    m_px = m_q.pop_front();
    if (collision && (m_st == M_GROUND || m_st == M_AIR)) begin
      m_st = M_OVER;
    end else if (m_st == M_IDLE || m_st == M_OVER) begin
      if (press == 1) begin
        m_st = M_GROUND; m_t = 0; m_buf = 0; m_req = 0;
      end
    end else if (m_st == M_GROUND) begin
      if (tick == 1 && (m_req == 1 || press == 1)) begin
        m_st = M_AIR; m_t = 1; m_req = 0;
      end else if (press == 1) begin
        m_req = 1;
      end
    end else begin
      press_ok = (press == 1 && BF > 0 && m_t >= T - BF) ? 1 : 0;
      if (press_ok == 1) m_buf = 1;
      if (tick == 1) begin
        if (m_t < T - 1) m_t++;
        else if (m_buf == 1) begin m_t = 1; m_buf = 0; end
        else begin m_st = M_GROUND; m_t = 0; end
      end
    end
    m_fd = int'(fresh);
    m_bd = int'(button_jump);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("game_status", int'(game_status), (m_st == M_GROUND || m_st == M_AIR) ? 1 : 0);
    chk("airborne", int'(airborne), (m_st == M_AIR) ? 1 : 0);
    chk("height", int'(height), m_height(m_t));
    chk("px", int'(vif.px), m_px);
    chk("rom_addr", int'(vif.rom_addr), m_addr);
  endtask

  task automatic tick1();
    fresh = 1'b1; step();
    fresh = 1'b0; step();
  endtask

  task automatic press1();
    button_jump = 1'b1; step();
    button_jump = 1'b0; step();
  endtask

  typedef struct {
    logic rst_n, fresh, btn, coll;
    int   gs, air, h;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst_n = 1'b0; fresh = 1'b0; button_jump = 1'b0; collision = 1'b0;
    vif.row_addr = '0; vif.col_addr = '0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 14};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 14};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 28};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 28};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 28};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0};

    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst_n; fresh = tbl[i].fresh;
      button_jump = tbl[i].btn; collision = tbl[i].coll;
      step();
      chk("tbl_game_status", int'(game_status), tbl[i].gs);
      chk("tbl_airborne", int'(airborne), tbl[i].air);
      chk("tbl_height", int'(height), tbl[i].h);
    end
    collision = 1'b0; button_jump = 1'b0; step();

    // Full jump: takeoff, apex, landing on the 30th tick.
    press1(); tick1();
    chk("jump_t1_height", int'(height), 14);
    repeat (14) tick1();
    chk("jump_apex_height", int'(height), 112);
    repeat (14) tick1();
    chk("jump_t29_airborne", int'(airborne), 1);
    tick1();
    chk("land_airborne", int'(airborne), 0);
    chk("land_status", int'(game_status), 1);
    chk("land_height", int'(height), 0);

    // Buffered press at t=27 re-launches; press at t=20 is dropped.
    press1(); tick1();
    repeat (26) tick1();
    press1();
    repeat (2) tick1();
    tick1();
    chk("buf_airborne", int'(airborne), 1);
    chk("buf_height", int'(height), 14);
    repeat (19) tick1();
    press1();
    repeat (9) tick1();
    tick1();
    chk("nobuf_airborne", int'(airborne), 0);
    chk("nobuf_height", int'(height), 0);

    // Collision together with a tick at t=8 freezes height at 88.
    press1(); tick1();
    repeat (7) tick1();
    fresh = 1'b1; step();
    fresh = 1'b0; collision = 1'b1; step();
    collision = 1'b0;
    chk("over_status", int'(game_status), 0);
    chk("over_height", int'(height), 88);
    step();
    chk("over_frozen", int'(height), 88);
    press1();
    chk("restart_status", int'(game_status), 1);
    chk("restart_height", int'(height), 0);

    // Press and tick in one cycle takes off; a held button is one press.
    fresh = 1'b1; step();
    fresh = 1'b0; button_jump = 1'b1; step();
    chk("sametick_airborne", int'(airborne), 1);
    chk("sametick_height", int'(height), 14);
    repeat (29) tick1();
    chk("held_land_airborne", int'(airborne), 0);
    chk("held_land_height", int'(height), 0);
    button_jump = 1'b0; step();

    // Reset mid-air at t=10.
    press1(); tick1();
    repeat (9) tick1();
    chk("preset_height", int'(height), 10 * 20 / 2);
    rst_n = 1'b0; step();
    chk("rst_status", int'(game_status), 0);
    chk("rst_airborne", int'(airborne), 0);
    chk("rst_height", int'(height), 0);
    chk("rst_px", int'(vif.px), 0);
    rst_n = 1'b1; step();

    // Render latency and box edges at height 0.
    press1();
    vif.row_addr = 9'd314; vif.col_addr = 10'd81; step();
    chk("render_addr_1", int'(vif.rom_addr), 1);
    vif.row_addr = 9'd0; vif.col_addr = 10'd0; step();
    chk("render_lat1_px", int'(vif.px), 0);
    step();
    chk("render_lat2_px", int'(vif.px), 1);
    vif.row_addr = 9'd314; vif.col_addr = 10'd80; step();
    chk("render_addr_0", int'(vif.rom_addr), 0);
    vif.col_addr = 10'd162; step();
    chk("render_miss_hold", int'(vif.rom_addr), 0);
    step();
    chk("render_even_px", int'(vif.px), 0);
    vif.row_addr = 9'd401; vif.col_addr = 10'd161; step();
    chk("render_corner_addr", int'(vif.rom_addr), 7215);
    vif.row_addr = 9'd313; vif.col_addr = 10'd100; step();
    chk("render_above_hold", int'(vif.rom_addr), 7215);
    vif.row_addr = 9'd402; step();
    chk("render_corner_px", int'(vif.px), 1);
    step();
    chk("render_above_px", int'(vif.px), 0);

    // Random play against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 499) != 0);
      fresh        = ($urandom_range(0, 2) == 0);
      button_jump  = ($urandom_range(0, 3) == 0);
      collision    = ($urandom_range(0, 149) == 0);
      vif.row_addr = 9'($urandom_range(300, 410));
      vif.col_addr = 10'($urandom_range(70, 170));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
